register_file_mp: RTL



---
 rtl/register_file_pkg.sv | 27 ++
 rtl/register_file_scoreboard.sv | 57 +++++
 rtl/register_file_mp.sv | 99 +++++++++
 3 files changed

// File: rtl/register_file_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds address/data typedefs, the zero-register constant and write priority.
package register_file_pkg;

  localparam int AddrW    = 5;
  localparam int DataW    = 32;
  localparam int NumRegs  = 1 << AddrW;
  localparam int MaxPorts = 32;

  typedef logic [AddrW-1:0] reg_addr_t;
  typedef logic [DataW-1:0] reg_data_t;

  localparam reg_addr_t RegZero = '0;

  // Highest set bit of a per-port hit vector; -1 when nobody hits.
  function automatic int win_port(
    input logic [MaxPorts-1:0] hits
  );
    int w;
    w = -1;
    for (int p = 0; p < MaxPorts; p++) begin
      if (hits[p]) w = p;
    end
    return w;
  endfunction

endpackage

// File: rtl/register_file_scoreboard.sv
// Busy scoreboard: per-register reservation bits, issue-ready and count.
// Ports: clear mask from writeback, issue request, busy/set vectors, count.
module register_file_scoreboard
  import register_file_pkg::*;
#(
  parameter int AddressBitWidth = AddrW
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [(1<<AddressBitWidth)-1:0] clear_mask_i,
  input  logic                            issue_valid_i,
  input  logic [AddressBitWidth-1:0]      issue_rd_i,
  output logic [(1<<AddressBitWidth)-1:0] busy_o,
  output logic [(1<<AddressBitWidth)-1:0] set_mask_o,
  output logic                            issue_ready_o,
  output logic [AddressBitWidth:0]        pending_count_o
);

  localparam int NR = 1 << AddressBitWidth;

  logic [NR-1:0]            busy_q, busy_d;
  logic [AddressBitWidth:0] count_q, count_d;
  logic                     rd_zero;

  assign rd_zero = (issue_rd_i == AddressBitWidth'(RegZero));

  always_comb begin
    issue_ready_o = rd_zero
                  || !busy_q[issue_rd_i]
                  || clear_mask_i[issue_rd_i];
    set_mask_o = '0;
    if (issue_valid_i && issue_ready_o && !rd_zero)
      set_mask_o[issue_rd_i] = 1'b1;
  end

  // A reservation accepted alongside a write keeps the bit set.
  always_comb begin
    busy_d = (busy_q & ~clear_mask_i) | set_mask_o;
    count_d = '0;
    for (int r = 0; r < NR; r++)
      count_d = count_d + (AddressBitWidth+1)'(busy_d[r]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

  assign busy_o          = busy_q;
  assign pending_count_o = count_q;

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with write bypass and busy scoreboard.
// Ports: read addr/data/busy, write en/addr/data, issue req/ready, count.
module register_file_mp
  import register_file_pkg::*;
#(
  parameter int AddressBitWidth = AddrW,
  parameter int DataBitWidth    = DataW,
  parameter int ReadPorts       = 2,
  parameter int WritePorts      = 2,
  parameter int Bypass          = 1
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [ReadPorts-1:0][AddressBitWidth-1:0]  rs,
  output logic [ReadPorts-1:0][DataBitWidth-1:0]     rs_data_out,
  output logic [ReadPorts-1:0]                       rs_busy_out,
  input  logic [WritePorts-1:0]                      wr_enable,
  input  logic [WritePorts-1:0][AddressBitWidth-1:0] wr_rd,
  input  logic [WritePorts-1:0][DataBitWidth-1:0]    wr_data_in,
  input  logic                                       issue_valid,
  input  logic [AddressBitWidth-1:0]                 issue_rd,
  output logic                                       issue_ready_out,
  output logic [AddressBitWidth:0]                   pending_count_out
);

  localparam int NR = 1 << AddressBitWidth;

  logic [DataBitWidth-1:0] data_q [NR];
  logic [DataBitWidth-1:0] data_d [NR];
  logic [DataBitWidth-1:0] wr_val [NR];
  logic [NR-1:0]           wr_mask;
  logic [NR-1:0]           busy;
  logic [NR-1:0]           set_mask;

  // Resolve per-register winners; register 0 never takes a write.
  always_comb begin
    logic [MaxPorts-1:0] hits;
    int                  w;
    wr_mask = '0;
    for (int r = 0; r < NR; r++) begin
      hits = '0;
      wr_val[r] = '0;
      for (int p = 0; p < WritePorts; p++)
        hits[p] = wr_enable[p]
               && (wr_rd[p] == AddressBitWidth'(r));
      w = win_port(hits);
      if (r != 0) wr_mask[r] = |hits;
      for (int p = 0; p < WritePorts; p++)
        if (p == w) wr_val[r] = wr_data_in[p];
    end
  end

  always_comb begin
    for (int r = 0; r < NR; r++)
      data_d[r] = wr_mask[r] ? wr_val[r] : data_q[r];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NR; r++) data_q[r] <= '0;
    end else begin
      for (int r = 0; r < NR; r++) data_q[r] <= data_d[r];
    end
  end

  register_file_scoreboard #(
    .AddressBitWidth(AddressBitWidth)
  ) u_sb (
    .clk            (clk),
    .rst_n          (rst_n),
    .clear_mask_i   (wr_mask),
    .issue_valid_i  (issue_valid),
    .issue_rd_i     (issue_rd),
    .busy_o         (busy),
    .set_mask_o     (set_mask),
    .issue_ready_o  (issue_ready_out),
    .pending_count_o(pending_count_out)
  );

  // Bypassed busy reflects the same-cycle reservation, not the stale bit.
  always_comb begin
    logic [AddressBitWidth-1:0] a;
    for (int i = 0; i < ReadPorts; i++) begin
      a = rs[i];
      rs_data_out[i] = '0;
      rs_busy_out[i] = 1'b0;
      if (a != AddressBitWidth'(RegZero)) begin
        if (Bypass != 0 && wr_mask[a]) begin
          rs_data_out[i] = wr_val[a];
          rs_busy_out[i] = set_mask[a];
        end else begin
          rs_data_out[i] = data_q[a];
          rs_busy_out[i] = busy[a];
        end
      end
    end
  end

endmodule
